qtree_stream_player: RTL and testbench

- Synthesizable, parametrised stimulus/response engine for QTree stream kernels, for on-chip or simulation harnesses.
- Buffers up to DEPTH tokens, grouped into up to MAX_SEG segments.
- Replays the tokens over an AXI-stream master with correct valid/ready holding and tlast on each segment end.
- Captures the kernel's first flagged result and the cycle count from start to result.

---
 rtl/qtree_stream_player_if.sv | 12 +
 rtl/qtree_stream_player.sv | 203 ++++++++++++++++++++
 tb/tb_qtree_stream_player.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/qtree_stream_player_if.sv
// AXI-stream style token channel between the player and a QTree kernel.
interface qtree_stream_player_if #(
    parameter int DATA_W = 67
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/qtree_stream_player.sv
// Token buffer + segment table that replays a loaded token stream to a
// kernel over AXI-stream and captures the kernel's first flagged result
// together with the number of cycles it took.
module qtree_stream_player #(
    parameter int DATA_W  = 67,
    parameter int RES_W   = 32,
    parameter int DEPTH   = 256,
    parameter int MAX_SEG = 4,
    parameter int CNT_W   = 32
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   ld_valid,
    input  logic [DATA_W-1:0]      ld_data,
    input  logic                   ld_seg_end,
    input  logic                   start,
    input  logic                   clear,
    qtree_stream_player_if.master  m,
    input  logic [RES_W-1:0]       r_tdata,
    output logic                   done,
    output logic [RES_W-1:0]       result,
    output logic [CNT_W-1:0]       cycles,
    output logic [$clog2(DEPTH):0] tok_count,
    output logic [1:0]             err
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(MAX_SEG + 1);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {IDLE, PLAY, WAIT_RES, DONE} state_t;

    state_t            state_q, state_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;      // index of the next token to fetch
    logic [SW-1:0]     seg_cnt_q, seg_cnt_d;
    logic [1:0]        err_q, err_d;
    logic              done_q, done_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;

    logic [DATA_W-1:0] mem [DEPTH];
    ptr_t              seg_tbl [MAX_SEG];

    logic              wr_en, seg_wr;
    ptr_t              fetch_idx;
    logic              fetch_last;
    logic [DATA_W-1:0] mem_rd;

    // Shared decode used by both the next-state and datapath logic.
    logic in_run, cap, xfer, end_xfer, start_ok;
    assign in_run   = (state_q == PLAY) || (state_q == WAIT_RES);
    assign cap      = in_run && r_tdata[0];
    assign xfer     = tvalid_q && m.tready;
    assign end_xfer = xfer && (rd_ptr_q == wr_ptr_q);
    assign start_ok = start && (wr_ptr_q != '0) && ((state_q == IDLE) || (state_q == DONE));

    // On a (re)start the first token is fetched immediately so tvalid can rise next cycle.
    assign fetch_idx = start_ok ? '0 : rd_ptr_q;
    assign mem_rd    = mem[fetch_idx[AW-1:0]];

    // tlast on any recorded segment end, plus the implicit one on the final token.
    always_comb begin
        fetch_last = (fetch_idx == wr_ptr_q - ptr_t'(1));
        for (int i = 0; i < MAX_SEG; i++) begin
            if ((SW'(i) < seg_cnt_q) && (seg_tbl[i] == fetch_idx)) fetch_last = 1'b1;
        end
    end

    // Token RAM and segment table: not reset, validity is tracked by wr_ptr/seg_cnt.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= ld_data;
        for (int i = 0; i < MAX_SEG; i++) begin
            if (seg_wr && (seg_cnt_q == SW'(i))) seg_tbl[i] <= wr_ptr_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            seg_cnt_q <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            cycles_q  <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            seg_cnt_q <= seg_cnt_d;
            err_q     <= err_d;
            done_q    <= done_d;
            result_q  <= result_d;
            cycles_q  <= cycles_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tdata_q   <= tdata_d;
        end
    end

    // Next-state: clear wins, a capture wins over the end of the stream.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:     if (start_ok) state_d = PLAY;
                PLAY:     if (cap) state_d = DONE; else if (end_xfer) state_d = WAIT_RES;
                WAIT_RES: if (cap) state_d = DONE;
                DONE:     if (start_ok) state_d = PLAY;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath/outputs: loading, stream refill on handshake, counter and capture.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        seg_cnt_d = seg_cnt_q;
        err_d     = err_q;
        done_d    = done_q;
        result_d  = result_q;
        cycles_d  = cycles_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tdata_d   = tdata_q;
        wr_en     = 1'b0;
        seg_wr    = 1'b0;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            seg_cnt_d = '0;
            err_d     = '0;
            done_d    = 1'b0;
            result_d  = '0;
            cycles_d  = '0;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            tdata_d   = '0;
        end else if (start_ok) begin
            // Same path for first play and replay from DONE; result is kept.
            done_d   = 1'b0;
            cycles_d = '0;
            rd_ptr_d = ptr_t'(1);
            tvalid_d = 1'b1;
            tdata_d  = mem_rd;
            tlast_d  = fetch_last;
        end else if (state_q == IDLE) begin
            // A start in the same cycle (even an ignored one) suppresses the load.
            if (ld_valid && !start) begin
                if (wr_ptr_q == ptr_t'(DEPTH)) begin
                    err_d[0] = 1'b1;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ptr_t'(1);
                    if (ld_seg_end) begin
                        if (seg_cnt_q == SW'(MAX_SEG)) begin
                            err_d[1] = 1'b1;
                        end else begin
                            seg_wr    = 1'b1;
                            seg_cnt_d = seg_cnt_q + SW'(1);
                        end
                    end
                end
            end
        end else if (in_run) begin
            // The capture cycle itself is counted, so cycles = edges from accept to capture.
            if (cycles_q != '1) cycles_d = cycles_q + CNT_W'(1);
            if (cap) begin
                result_d = r_tdata;
                done_d   = 1'b1;
                tvalid_d = 1'b0;
            end else if (xfer) begin
                if (end_xfer) begin
                    tvalid_d = 1'b0;
                end else begin
                    tdata_d  = mem_rd;
                    tlast_d  = fetch_last;
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
            end
        end
    end

    assign m.tdata   = tdata_q;
    assign m.tvalid  = tvalid_q;
    assign m.tlast   = tlast_q;
    assign done      = done_q;
    assign result    = result_q;
    assign cycles    = cycles_q;
    assign tok_count = wr_ptr_q;
    assign err       = err_q;
endmodule

// File: tb/tb_qtree_stream_player.sv
// Directed bench for qtree_stream_player: a DEPTH=256 instance for the main
// flows and a DEPTH=8 instance for the overflow boundaries.
module tb_qtree_stream_player;
    localparam int DW = 67;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          ld_valid = 1'b0, ld_valid8 = 1'b0, ld_seg_end = 1'b0;
    logic          start = 1'b0, start8 = 1'b0, clear = 1'b0, clear8 = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic [31:0]   r_tdata = '0;

    logic          done, done8;
    logic [31:0]   result, result8, cycles, cycles8;
    logic [8:0]    tok_count;
    logic [3:0]    tok_count8;
    logic [1:0]    err, err8;

    qtree_stream_player_if #(.DATA_W(DW)) s_if ();
    qtree_stream_player_if #(.DATA_W(DW)) s8_if ();

    qtree_stream_player #(.DATA_W(DW), .DEPTH(256)) dut (
        .aclk(aclk), .aresetn(aresetn), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_seg_end(ld_seg_end), .start(start), .clear(clear), .m(s_if),
        .r_tdata(r_tdata), .done(done), .result(result), .cycles(cycles),
        .tok_count(tok_count), .err(err)
    );

    qtree_stream_player #(.DATA_W(DW), .DEPTH(8)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .ld_valid(ld_valid8), .ld_data(ld_data),
        .ld_seg_end(ld_seg_end), .start(start8), .clear(clear8), .m(s8_if),
        .r_tdata(r_tdata), .done(done8), .result(result8), .cycles(cycles8),
        .tok_count(tok_count8), .err(err8)
    );

    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DW-1:0] tok(input int i);
        return {3'b101, 32'hC0DE_0000 + 32'(i), 32'(i)};
    endfunction

    logic [21:0]   seg_mask = 22'h208420;   // tlast on 5, 10, 15, 21
    logic [7:0]    seg_mask8 = 8'h8F;       // marks 0..3 kept, 4 dropped, implicit 7
    int            idx, c;
    logic          stall;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    initial begin
        s_if.tready  = 1'b0;
        s8_if.tready = 1'b0;

        // Reset for two cycles: everything observable is zero.
        aresetn = 1'b0;
        tick(); tick();
        chk("rst_tvalid", s_if.tvalid, 0);
        chk("rst_tdata", s_if.tdata, 0);
        chk("rst_tlast", s_if.tlast, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_tok", tok_count, 0);
        chk("rst_err", err, 0);
        aresetn = 1'b1;
        tick();

        // Start with an empty buffer is ignored.
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_start_tvalid0", s_if.tvalid, 0);
        tick();
        chk("empty_start_tvalid1", s_if.tvalid, 0);

        // Load 22 tokens, segment ends on 5, 10, 15, 21.
        for (int i = 0; i < 22; i++) begin
            ld_valid = 1'b1; ld_data = tok(i); ld_seg_end = seg_mask[i];
            tick();
        end
        ld_valid = 1'b0; ld_seg_end = 1'b0;
        chk("load_tok", tok_count, 22);
        chk("load_err", err, 0);

        // Full-rate playback; a load alongside start must be ignored.
        s_if.tready = 1'b1;
        start = 1'b1; ld_valid = 1'b1; ld_data = tok(99);
        tick();
        start = 1'b0; ld_valid = 1'b0;
        chk("start_ld_ignored", tok_count, 22);
        for (int i = 0; i < 22; i++) begin
            chk("fr_valid", s_if.tvalid, 1);
            chk("fr_data", s_if.tdata, tok(i));
            chk("fr_last", s_if.tlast, seg_mask[i]);
            tick();
        end
        chk("fr_valid_end", s_if.tvalid, 0);
        chk("fr_done0", done, 0);

        // Result 7 cycles after the last handshake: 22 + 7 edges after accept.
        repeat (6) tick();
        r_tdata = 32'h0000_002B;
        tick();
        r_tdata = '0;
        chk("cap_done", done, 1);
        chk("cap_result", result, 32'h2B);
        chk("cap_cycles", cycles, 29);
        r_tdata = 32'h0000_0077;           // ignored in DONE
        tick(); tick();
        r_tdata = '0;
        chk("done_hold_result", result, 32'h2B);
        chk("done_hold_cycles", cycles, 29);
        chk("done_hold_done", done, 1);
        chk("done_hold_tvalid", s_if.tvalid, 0);

        // Replay from DONE with ready toggling 1,0,0,1.
        start = 1'b1; tick(); start = 1'b0;
        chk("rp_done_clr", done, 0);
        chk("rp_cycles_clr", cycles, 0);
        chk("rp_result_kept", result, 32'h2B);
        idx = 0; c = 0; stall = 1'b0; hold_d = '0; hold_l = 1'b0;
        while (idx < 22 && c < 300) begin
            s_if.tready = ((c % 4) == 0) || ((c % 4) == 3);
            chk("bp_valid", s_if.tvalid, 1);
            if (stall) begin
                chk("bp_hold_data", s_if.tdata, hold_d);
                chk("bp_hold_last", s_if.tlast, hold_l);
            end
            chk("bp_data", s_if.tdata, tok(idx));
            chk("bp_last", s_if.tlast, seg_mask[idx]);
            stall  = !s_if.tready;
            hold_d = s_if.tdata;
            hold_l = s_if.tlast;
            if (s_if.tready) idx++;
            tick();
            c++;
        end
        chk("bp_count", idx, 22);
        chk("bp_valid_end", s_if.tvalid, 0);
        r_tdata = 32'h0000_0101;
        tick();
        r_tdata = '0;
        chk("bp_cap_result", result, 32'h101);
        chk("bp_cap_cycles", cycles, c + 1);

        // Abort: result flagged while token 3 is on the bus.
        s_if.tready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("ab_data3", s_if.tdata, tok(3));
        r_tdata = 32'h0000_0055;
        tick();
        r_tdata = '0;
        chk("ab_tvalid", s_if.tvalid, 0);
        chk("ab_done", done, 1);
        chk("ab_result", result, 32'h55);
        chk("ab_cycles", cycles, 4);
        tick();
        chk("ab_tvalid_hold", s_if.tvalid, 0);

        // Clear mid-PLAY.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("cl_playing", s_if.tvalid, 1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("cl_tvalid", s_if.tvalid, 0);
        chk("cl_tdata", s_if.tdata, 0);
        chk("cl_tlast", s_if.tlast, 0);
        chk("cl_tok", tok_count, 0);
        chk("cl_done", done, 0);
        chk("cl_result", result, 0);
        chk("cl_cycles", cycles, 0);
        chk("cl_err", err, 0);
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("cl_empty_start", s_if.tvalid, 0);

        // DEPTH=8 instance: 9 loads, 5 segment marks.
        for (int i = 0; i < 9; i++) begin
            ld_valid8 = 1'b1; ld_data = tok(40 + i); ld_seg_end = (i <= 4);
            tick();
        end
        ld_valid8 = 1'b0; ld_seg_end = 1'b0;
        chk("ov_tok", tok_count8, 8);
        chk("ov_err", err8, 2'b11);
        s8_if.tready = 1'b1;
        start8 = 1'b1; tick(); start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ov_valid", s8_if.tvalid, 1);
            chk("ov_data", s8_if.tdata, tok(40 + i));
            chk("ov_last", s8_if.tlast, seg_mask8[i]);
            tick();
        end
        chk("ov_valid_end", s8_if.tvalid, 0);

        // Reset mid-PLAY.
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = tok(60 + i);
            tick();
        end
        ld_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("mr_playing", s_if.tvalid, 1);
        aresetn = 1'b0;
        tick();
        chk("mr_tvalid", s_if.tvalid, 0);
        chk("mr_tdata", s_if.tdata, 0);
        chk("mr_tlast", s_if.tlast, 0);
        chk("mr_tok", tok_count, 0);
        chk("mr_done", done, 0);
        chk("mr_cycles", cycles, 0);
        chk("mr_err8", err8, 0);
        chk("mr_tok8", tok_count8, 0);
        aresetn = 1'b1;
        tick();
        chk("mr_tvalid_after", s_if.tvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
